// File: rtl/modport_fifo_pkg.sv
// rtl/modport_fifo_pkg.sv - default FIFO geometry, flag thresholds and pointer/count width helpers
package modport_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AF_LEVEL   = 14;
    localparam int DEF_AE_LEVEL   = 2;

    // Pointer width for a power-of-two depth; the occupancy count needs one extra bit
    // so that a full FIFO (count == DEPTH) is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_width(DEF_DEPTH)-1:0] ptr_t;
    typedef logic [cnt_width(DEF_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/modport_fifo_mem.sv
// rtl/modport_fifo_mem.sv - DEPTH x DATA_WIDTH storage, synchronous write port, registered read port
//   clk      : clock, rising edge
//   reset    : synchronous active-high, clears the read register only
//   wr_en    : write strobe; wr_data stored at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data loads mem[rd_addr], otherwise holds
//   rd_addr  : read address
//   rd_data  : registered read data
module modport_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - single-clock FIFO with full/empty/almost-full/almost-empty flags
//   clk               : clock, rising edge
//   reset             : synchronous active-high reset
//   wr_en             : write request, accepted when not full
//   rd_en             : read request, accepted when not empty
//   data_in           : write data
//   data_out          : registered read data, valid one cycle after an accepted read
//   fifo_full         : occupancy == DEPTH
//   fifo_empty        : occupancy == 0
//   fifo_almost_full  : occupancy >= AF_LEVEL
//   fifo_almost_empty : occupancy <= AE_LEVEL
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_wr_acc;
    logic w_rd_acc;

    // Flags come straight from the registered count, so they never depend
    // combinationally on wr_en/rd_en.
    assign fifo_full         = (r_count == C_DEPTH);
    assign fifo_empty        = (r_count == '0);
    assign fifo_almost_full  = (r_count >= C_AF);
    assign fifo_almost_empty = (r_count <= C_AE);

    // Each request is qualified on its own; a simultaneous write into an empty
    // FIFO is not forwarded to the read side in the same cycle.
    assign w_wr_acc = wr_en & ~fifo_full;
    assign w_rd_acc = rd_en & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset gates the read strobe inside the memory; a stray write during reset
    // only touches storage, which is don't-care after reset anyway.
    modport_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wptr),
        .wr_data (data_in),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - directed scoreboard bench for modport_fifo
module tb_modport_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] last_out;

    modport_fifo dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .rd_en             (rd_en),
        .data_in           (data_in),
        .data_out          (data_out),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = model_q.size();
        chk_bit({tag, ".full"},   fifo_full,         n == DEPTH);
        chk_bit({tag, ".empty"},  fifo_empty,        n == 0);
        chk_bit({tag, ".afull"},  fifo_almost_full,  n >= AF);
        chk_bit({tag, ".aempty"}, fifo_almost_empty, n <= AE);
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit wa, ra;
        wa = w && (model_q.size() != DEPTH);
        ra = r && (model_q.size() != 0);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        if (exp_q.size() != 0) last_out = exp_q.pop_front();
        chk_word({tag, ".data_out"}, data_out, last_out);
        chk_flags(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_out = '0;
        chk_word({tag, ".data_out"}, data_out, 32'h0);
        chk_flags(tag);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        last_out = '0;
        @(posedge clk);
        do_reset("reset");

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, "idle");

        // Fill to full, then one dropped write.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i), "fill");
        step(1'b1, 1'b0, 32'hDEADBEEF, "overflow");
        chk_bit("full_after_overflow", fifo_full, 1'b1);

        // Drain: 1..16 in order, then an underflow read holds the last word.
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 32'h0, "drain");
        step(1'b0, 1'b1, 32'h0, "underflow");
        chk_word("underflow_hold", data_out, 32'h00000010);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h50 + DW'(i), "wrap_w10");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h0, "wrap_r10");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'hA0 + DW'(i), "wrap_w12");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 32'h0, "wrap_r12");
        chk_word("wrap_last", data_out, 32'h000000AB);

        // Simultaneous read/write with 4 words stored.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hC0 + DW'(i), "sim4_pre");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'hD0 + DW'(i), "sim4");
        chk_bit("sim4_not_empty", fifo_empty, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0, "sim4_drain");
        chk_word("sim4_tail", data_out, 32'h000000E3);

        // Simultaneous read/write from empty: first cycle is write-only.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'hF0 + DW'(i), "sim0");
        step(1'b0, 1'b1, 32'h0, "sim0_drain");
        chk_word("sim0_tail", data_out, 32'h00000103);
        chk_bit("sim0_empty", fifo_empty, 1'b1);

        // Reset mid-stream discards stored data.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h300 + DW'(i), "pre_reset");
        step(1'b0, 1'b1, 32'h0, "pre_reset_rd");
        do_reset("midreset");
        step(1'b0, 1'b1, 32'h0, "post_reset_rd");
        chk_word("post_reset_data", data_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
